// File: rtl/if_prefetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_stage_pkg
//  Description : Shared widths, reset defaults and helpers for the
//                instruction-fetch prefetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_prefetch_stage_pkg;

    localparam int unsigned c_WORD_LEN_DEF = 32;
    localparam int unsigned c_ADDR_LEN_DEF = 32;
    localparam int unsigned c_RESET_PC_DEF = 0;
    localparam int unsigned c_INSTR_SH_DEF = 2;

    // Width of a counter that must hold every value 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_stage_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_stage_sync_fifo
//  Description : Synchronous FIFO with push/pop, occupancy count and a
//                synchronous clear. DEPTH must be a power of two (>= 2) so
//                pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_stage_sync_fifo
    import if_prefetch_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clr,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [cnt_width(DEPTH)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO may still accept a push when the head leaves the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; clear discards everything stored
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage array write; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_stage
//  Description : Instruction-fetch stage: PC generation, pipelined in-order
//                requests to a variable-latency instruction memory, and a
//                DEPTH-entry prefetch queue feeding decode. Branch redirects
//                flush the queue and discard responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int                    WORD_LEN = c_WORD_LEN_DEF,
    parameter int                    ADDR_LEN = c_ADDR_LEN_DEF,
    parameter int                    DEPTH    = 4,
    parameter logic [ADDR_LEN-1:0]   RESET_PC = ADDR_LEN'(c_RESET_PC_DEF),
    parameter int                    INSTR_SH = c_INSTR_SH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  brTaken,
    input  logic [ADDR_LEN-1:0]   brPC,
    input  logic [WORD_LEN-1:0]   brOffset,
    output logic                  memReqValid,
    input  logic                  memReqReady,
    output logic [ADDR_LEN-1:0]   memReqAddr,
    input  logic                  memRespValid,
    input  logic [WORD_LEN-1:0]   memRespData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [ADDR_LEN-1:0]   PC,
    output logic [WORD_LEN-1:0]   instruction
);

    localparam int                  CW          = cnt_width(DEPTH);
    localparam logic [ADDR_LEN-1:0] c_STEP      = ADDR_LEN'(1) << INSTR_SH;
    localparam logic [CW:0]         c_DEPTH_EXT = (CW+1)'(DEPTH);

    logic [ADDR_LEN-1:0]          r_fetch_pc;
    logic [CW-1:0]                r_inflight;
    logic [CW-1:0]                r_drop_cnt;

    logic [ADDR_LEN-1:0]          w_off_ext;
    logic [ADDR_LEN-1:0]          w_target;
    logic                         w_credit_ok;
    logic                         w_accept;
    logic                         w_resp_keep;
    logic                         w_pop;

    logic [ADDR_LEN-1:0]          w_tag_pc;
    logic                         w_tag_full;
    logic                         w_tag_empty;
    logic [CW-1:0]                w_tag_count;

    logic [ADDR_LEN+WORD_LEN-1:0] w_q_data;
    logic                         w_q_full;
    logic                         w_q_empty;
    logic [CW-1:0]                w_q_count;

    // Branch target: offset counts instructions, so scale it to bytes
    assign w_off_ext = ADDR_LEN'($signed(brOffset));
    assign w_target  = brPC + (w_off_ext << INSTR_SH);

    // Queued plus outstanding never exceeds DEPTH, so responses always fit
    assign w_credit_ok = ({1'b0, w_q_count} + {1'b0, r_inflight}) < c_DEPTH_EXT;
    assign memReqValid = w_credit_ok && !brTaken && !rst;
    assign memReqAddr  = r_fetch_pc;
    assign w_accept    = memReqValid && memReqReady;

    // Stale responses (pending drops, or arriving with a redirect) are discarded
    assign w_resp_keep = memRespValid && (r_drop_cnt == '0) && !brTaken;

    assign outValid    = !w_q_empty;
    assign w_pop       = outValid && outReady;
    assign PC          = outValid ? w_q_data[WORD_LEN +: ADDR_LEN] : '0;
    assign instruction = outValid ? w_q_data[WORD_LEN-1:0]         : '0;

    // Fetch address: redirect beats sequential advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (brTaken) begin
            r_fetch_pc <= w_target;
        end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + c_STEP;
        end
    end

    // Outstanding request count, dropped or not
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_accept, memRespValid})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // On redirect every request still outstanding becomes stale; a response
    // arriving in the redirect cycle is already discarded and not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (brTaken) begin
            r_drop_cnt <= r_inflight - (memRespValid ? CW'(1) : CW'(0));
        end else if (memRespValid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
        end
    end

    // Fetch PCs of live outstanding requests, in request order
    if_prefetch_stage_sync_fifo #(
        .WIDTH (ADDR_LEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (brTaken),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (w_resp_keep),
        .o_data  (w_tag_pc),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    // Prefetch queue of {PC, instruction} pairs presented to decode
    if_prefetch_stage_sync_fifo #(
        .WIDTH (ADDR_LEN + WORD_LEN),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (brTaken),
        .i_push  (w_resp_keep),
        .i_data  ({w_tag_pc, memRespData}),
        .i_pop   (w_pop),
        .o_data  (w_q_data),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // Protocol sanity: memory must not answer unrequested, and bookkeeping must agree
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(memRespValid && (r_inflight == '0)));
            assert (!(w_resp_keep && w_tag_empty));
            assert (!(w_resp_keep && w_q_full && !w_pop));
            assert (!(w_accept && w_tag_full));
            assert (w_tag_count <= r_inflight);
        end
    end

endmodule
`default_nettype wire
